// File: rtl/mc_defs.sv
// Shared encodings for the multi-cycle sequencer: states, opcodes/functs,
// ALU and next-PC select codes, and the control word driven onto the datapath.
package mc_defs;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] npc_sel;
        logic       reg_wr;
        logic       reg_dst;
        logic       ext_op;
        logic       alu_src;
        logic [2:0] alu_ctr;
        logic       mem_wr;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BGTZ, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control-word decode from the current state and the
// instruction fields latched in DECODE.
module mc_decode
    import mc_defs::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       msb,
    input  logic       mem_done,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.alu_ctr = ALU_ADD;
        ctrl.npc_sel = NPC_SEQ;

        // ALU operand setup stays stable from EXEC through WB
        if (state inside {S_EXEC, S_MEM, S_WB}) begin
            if (opcode == OP_RTYPE) begin
                ctrl.alu_ctr = rtype_alu(funct);
            end else if (opcode inside {OP_ADDI, OP_LW, OP_SW}) begin
                ctrl.alu_src = 1'b1;
                ctrl.ext_op  = 1'b1;
            end else if (opcode inside {OP_BEQ, OP_BGTZ}) begin
                ctrl.alu_ctr = ALU_SUB;
            end
        end

        case (state)
            S_FETCH: ctrl.ir_wr = 1'b1;
            S_EXEC: begin
                case (opcode)
                    OP_BEQ: begin
                        ctrl.pc_wr   = 1'b1;
                        ctrl.npc_sel = zero ? NPC_BR : NPC_SEQ;
                    end
                    OP_BGTZ: begin
                        ctrl.pc_wr   = 1'b1;
                        ctrl.npc_sel = (!zero && !msb) ? NPC_BR : NPC_SEQ;
                    end
                    OP_J: begin
                        ctrl.pc_wr   = 1'b1;
                        ctrl.npc_sel = NPC_JMP;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    ctrl.mem_wr = 1'b1;
                    ctrl.pc_wr  = mem_done;
                end
            end
            S_WB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.pc_wr      = 1'b1;
                ctrl.reg_dst    = (opcode == OP_RTYPE);
                ctrl.mem_to_reg = (opcode == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with run/halt and a
// retired-instruction counter. MULTICYCLE_MEM_WAIT_EN adds mem_ready stalls in MEM.
module multicycle_control
    import mc_defs::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             start_up_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             msb,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       npc_sel,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             ext_op,
    output logic             alu_src,
    output logic [2:0]       alu_ctr,
    output logic             mem_wr,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       mem_done;
    logic       dec_halt;
    logic       dec_bad;
    ctrl_t      ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    assign dec_halt = (opcode == HALT_OP);
    assign dec_bad  = !dec_halt && !is_supported(opcode, funct);

    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            cur_state <= S_IDLE;
            op_q      <= '0;
            fn_q      <= '0;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
                if (dec_bad) illegal <= 1'b1;
            end
            if (ctrl.pc_wr) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   if (run) nxt_state = S_FETCH;
            S_FETCH:  nxt_state = run ? S_DECODE : S_IDLE;
            S_DECODE: nxt_state = (dec_halt || dec_bad) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: nxt_state = S_WB;
                    OP_LW, OP_SW:      nxt_state = S_MEM;
                    default:           nxt_state = S_FETCH;
                endcase
            end
            S_MEM:  if (mem_done) nxt_state = (op_q == OP_LW) ? S_WB : S_FETCH;
            S_WB:   nxt_state = S_FETCH;
            S_HALT: nxt_state = S_HALT;
            default: nxt_state = S_IDLE;
        endcase
    end

    mc_decode u_decode (
        .state    (cur_state),
        .opcode   (op_q),
        .funct    (fn_q),
        .zero     (zero),
        .msb      (msb),
        .mem_done (mem_done),
        .ctrl     (ctrl)
    );

    assign ir_wr      = ctrl.ir_wr & run;
    assign pc_wr      = ctrl.pc_wr;
    assign npc_sel    = ctrl.npc_sel;
    assign reg_wr     = ctrl.reg_wr;
    assign reg_dst    = ctrl.reg_dst;
    assign ext_op     = ctrl.ext_op;
    assign alu_src    = ctrl.alu_src;
    assign alu_ctr    = ctrl.alu_ctr;
    assign mem_wr     = ctrl.mem_wr;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign state      = cur_state;
    assign halted     = (cur_state == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its states and checks control outputs, counter, halt/illegal and reset abort.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             start_up_n;
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             msb;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic             mem_ready;
`endif
    logic             ir_wr;
    logic             pc_wr;
    logic [1:0]       npc_sel;
    logic             reg_wr;
    logic             reg_dst;
    logic             ext_op;
    logic             alu_src;
    logic [2:0]       alu_ctr;
    logic             mem_wr;
    logic             mem_to_reg;
    logic [2:0]       state;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CNT_W), .HALT_OP(6'h3F)) dut (
        .clk        (clk),
        .start_up_n (start_up_n),
        .run        (run),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .msb        (msb),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .npc_sel    (npc_sel),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .ext_op     (ext_op),
        .alu_src    (alu_src),
        .alu_ctr    (alu_ctr),
        .mem_wr     (mem_wr),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .halted     (halted),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        start_up_n = 1'b1; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0; msb = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        #1 start_up_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_alu_ctr", 32'(alu_ctr), 32'h2);
        chk("rst_npc_sel", 32'(npc_sel), 0);
        chk("rst_pc_wr", 32'(pc_wr), 0);
        chk("rst_ir_wr", 32'(ir_wr), 0);
        chk("rst_halted", 32'(halted), 0);

        @(negedge clk); start_up_n = 1'b1; run = 1'b1;

        // add: FETCH, DECODE, EXEC, WB
        cyc; chk("add_fetch_state", 32'(state), 1); chk("add_fetch_ir_wr", 32'(ir_wr), 1);
        opcode = 6'h00; funct = 6'h20;
        cyc; chk("add_decode_state", 32'(state), 2); chk("add_decode_pc_wr", 32'(pc_wr), 0);
        cyc; chk("add_exec_state", 32'(state), 3); chk("add_exec_alu_ctr", 32'(alu_ctr), 32'h2);
        chk("add_exec_alu_src", 32'(alu_src), 0); chk("add_exec_pc_wr", 32'(pc_wr), 0);
        cyc; chk("add_wb_state", 32'(state), 5); chk("add_wb_reg_wr", 32'(reg_wr), 1);
        chk("add_wb_reg_dst", 32'(reg_dst), 1); chk("add_wb_pc_wr", 32'(pc_wr), 1);
        chk("add_wb_mem_to_reg", 32'(mem_to_reg), 0); chk("add_wb_mem_wr", 32'(mem_wr), 0);
        cyc; chk("add_cnt", 32'(instr_cnt), 1); chk("add_next_fetch", 32'(state), 1);

        // lw: 5 cycles, MEM holds address setup, WB from memory
        opcode = 6'h23;
        cyc; cyc; chk("lw_exec_alu_src", 32'(alu_src), 1); chk("lw_exec_ext_op", 32'(ext_op), 1);
        cyc; chk("lw_mem_state", 32'(state), 4); chk("lw_mem_pc_wr", 32'(pc_wr), 0);
        chk("lw_mem_mem_wr", 32'(mem_wr), 0); chk("lw_mem_alu_src", 32'(alu_src), 1);
        chk("lw_mem_alu_ctr", 32'(alu_ctr), 32'h2);
        cyc; chk("lw_wb_state", 32'(state), 5); chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_wb_reg_dst", 32'(reg_dst), 0); chk("lw_wb_pc_wr", 32'(pc_wr), 1);
        cyc; chk("lw_cnt", 32'(instr_cnt), 2);

        // sw: retires from MEM
        opcode = 6'h2B;
        cyc; cyc; cyc; chk("sw_mem_state", 32'(state), 4); chk("sw_mem_mem_wr", 32'(mem_wr), 1);
        chk("sw_mem_pc_wr", 32'(pc_wr), 1); chk("sw_mem_reg_wr", 32'(reg_wr), 0);
        cyc; chk("sw_cnt", 32'(instr_cnt), 3); chk("sw_next_fetch", 32'(state), 1);

        // beq taken
        opcode = 6'h04; zero = 1'b1;
        cyc; cyc; chk("beq_t_npc", 32'(npc_sel), 1); chk("beq_t_pc_wr", 32'(pc_wr), 1);
        chk("beq_t_alu_ctr", 32'(alu_ctr), 32'h6);
        cyc; chk("beq_t_cnt", 32'(instr_cnt), 4); chk("beq_t_fetch", 32'(state), 1);

        // beq not taken
        zero = 1'b0;
        cyc; cyc; chk("beq_n_npc", 32'(npc_sel), 0); chk("beq_n_pc_wr", 32'(pc_wr), 1);
        cyc; chk("beq_n_cnt", 32'(instr_cnt), 5);

        // bgtz with negative result: not taken
        opcode = 6'h07; msb = 1'b1;
        cyc; cyc; chk("bgtz_neg_npc", 32'(npc_sel), 0);
        cyc; chk("bgtz_neg_cnt", 32'(instr_cnt), 6);

        // bgtz with positive result: taken
        msb = 1'b0;
        cyc; cyc; chk("bgtz_pos_npc", 32'(npc_sel), 1);
        cyc; chk("bgtz_pos_cnt", 32'(instr_cnt), 7);

        // slt
        opcode = 6'h00; funct = 6'h2A;
        cyc; cyc; chk("slt_exec_alu_ctr", 32'(alu_ctr), 32'h7);
        cyc; chk("slt_wb_reg_dst", 32'(reg_dst), 1);
        cyc; chk("slt_cnt", 32'(instr_cnt), 8);

        // j
        opcode = 6'h02;
        cyc; cyc; chk("j_npc", 32'(npc_sel), 2); chk("j_pc_wr", 32'(pc_wr), 1);
        cyc; chk("j_cnt", 32'(instr_cnt), 9);

        // addi with run dropped during EXEC
        opcode = 6'h08;
        cyc; cyc; chk("addi_exec_alu_src", 32'(alu_src), 1); chk("addi_exec_ext_op", 32'(ext_op), 1);
        run = 1'b0;
        cyc; chk("addi_wb_state", 32'(state), 5); chk("addi_wb_reg_wr", 32'(reg_wr), 1);
        chk("addi_wb_reg_dst", 32'(reg_dst), 0); chk("addi_wb_mem_to_reg", 32'(mem_to_reg), 0);
        cyc; chk("stop_fetch_state", 32'(state), 1); chk("stop_fetch_ir_wr", 32'(ir_wr), 0);
        chk("addi_cnt", 32'(instr_cnt), 10);
        cyc; chk("stop_idle_state", 32'(state), 0);
        cyc; chk("stop_idle_stays", 32'(state), 0);

        // illegal opcode
        run = 1'b1;
        cyc; opcode = 6'h11;
        cyc; cyc; chk("ill_state", 32'(state), 6); chk("ill_illegal", 32'(illegal), 1);
        chk("ill_halted", 32'(halted), 1); chk("ill_cnt", 32'(instr_cnt), 10);
        cyc; cyc; chk("ill_stay", 32'(state), 6); chk("ill_pc_wr", 32'(pc_wr), 0);
        chk("ill_cnt_hold", 32'(instr_cnt), 10);

        // reset clears sticky state
        start_up_n = 1'b0; #1;
        chk("rst2_state", 32'(state), 0); chk("rst2_illegal", 32'(illegal), 0);
        chk("rst2_cnt", 32'(instr_cnt), 0);
        @(negedge clk); start_up_n = 1'b1;

        // reset during MEM of sw aborts the write asynchronously
        cyc; opcode = 6'h2B;
        cyc; cyc; cyc; chk("abort_pre_mem_wr", 32'(mem_wr), 1);
        start_up_n = 1'b0; #1;
        chk("abort_mem_wr", 32'(mem_wr), 0); chk("abort_state", 32'(state), 0);
        chk("abort_cnt", 32'(instr_cnt), 0); chk("abort_pc_wr", 32'(pc_wr), 0);
        @(negedge clk); start_up_n = 1'b1;

`ifdef MULTICYCLE_MEM_WAIT_EN
        // sw stalled three cycles in MEM
        cyc; opcode = 6'h2B; mem_ready = 1'b0;
        cyc; cyc; cyc;
        for (int i = 0; i < 3; i++) begin
            chk("wait_mem_wr", 32'(mem_wr), 1); chk("wait_pc_wr", 32'(pc_wr), 0);
            chk("wait_state", 32'(state), 4);
            if (i < 2) cyc;
        end
        cyc; chk("wait_hold_state", 32'(state), 4);
        mem_ready = 1'b1; #1;
        chk("wait_ready_mem_wr", 32'(mem_wr), 1); chk("wait_ready_pc_wr", 32'(pc_wr), 1);
        cyc; chk("wait_cnt", 32'(instr_cnt), 1); chk("wait_fetch", 32'(state), 1);
        exp_cnt = 1;
`else
        cyc;
        exp_cnt = 0;
`endif

        // halt opcode
        opcode = 6'h3F;
        cyc; cyc; chk("halt_state", 32'(state), 6); chk("halt_halted", 32'(halted), 1);
        chk("halt_illegal", 32'(illegal), 0); chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
        cyc; cyc; chk("halt_pc_wr", 32'(pc_wr), 0); chk("halt_cnt_hold", 32'(instr_cnt), 32'(exp_cnt));
        chk("halt_ir_wr", 32'(ir_wr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
